// File: rtl/forward_scoreboard_id.sv
// ============================================================================
// Module   : forward_scoreboard_id
// Purpose  : ID-stage hazard scoreboard. Tracks the destination register of
//            every in-flight producer (slot 0 = EX, 1 = MEM, 2 = WB, ...).
//            For each register read port it chooses a forwarding source, or
//            raises a stall when the youngest matching producer cannot yet
//            supply its result.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            pipe_en           - pipeline advance (0 = every slot holds)
//            id_valid, id_RegWrite, id_MemRead, id_write_addr, id_flush
//                              - description of the instruction now in ID
//            rd_en, rd_addr    - per-port read enables / packed addresses
//            fwd_sel           - per-port source (0 = regfile, k = slot k)
//            stall             - hold IF/ID and insert a bubble
//            stall_cycles      - saturating count of stalled advance cycles
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_scoreboard_id #(
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int CW    = 16,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_en,
  input  logic                  id_valid,
  input  logic                  id_RegWrite,
  input  logic                  id_MemRead,
  input  logic [AW-1:0]         id_write_addr,
  input  logic                  id_flush,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*SW-1:0]   fwd_sel,
  output logic                  stall,
  output logic [CW-1:0]         stall_cycles
);

  // --------------------------------------------------------------------------
  // Producer slot state
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_load;
  logic [AW-1:0]    slot_waddr [DEPTH];
  logic [DEPTH-1:0] slot_ready;

  logic [NREAD-1:0] hazard;
  logic             slot0_valid_nxt;

  // A slot can forward once its result exists: ALU results are available
  // from slot 1 on, load data only from slot 2 on. Slot 0 is still executing.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_ready
      if (k == 0) begin : g_ex
        assign slot_ready[k] = 1'b0;
      end else begin : g_later
        assign slot_ready[k] = ~slot_load[k] | (k >= 2);
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Per-port youngest-match search
  // --------------------------------------------------------------------------
  generate
    for (genvar p = 0; p < NREAD; p++) begin : g_port
      logic [AW-1:0] addr;
      logic          active;
      logic          hit;
      logic          hit_ready;
      logic [SW-1:0] hit_idx;

      assign addr   = rd_addr[p*AW +: AW];
      // $0 is hard-wired zero, so reads of it never depend on a producer.
      assign active = rd_en[p] && (addr != '0);

      // Scan oldest to youngest so the youngest match is left standing;
      // an older ready copy must never hide a younger not-ready one.
      always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_idx   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (slot_valid[k] && (slot_waddr[k] == addr)) begin
            hit       = 1'b1;
            hit_ready = slot_ready[k];
            hit_idx   = SW'(k);
          end
        end
      end

      assign hazard[p] = active & hit & ~hit_ready;
      assign fwd_sel[p*SW +: SW] =
        (!reset && active && hit && hit_ready) ? hit_idx : '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stall: only a live, non-squashed ID instruction can be held. Reset drops
  // it immediately so a reset issued mid-stall releases the front end.
  // --------------------------------------------------------------------------
  assign stall = ~reset & id_valid & ~id_flush & (|hazard);

  // A stalled or squashed ID instruction enters EX as a bubble; writes to
  // $0 are never tracked because nothing can depend on them.
  assign slot0_valid_nxt = id_valid & id_RegWrite & ~id_flush & ~stall &
                           (id_write_addr != '0);

  // --------------------------------------------------------------------------
  // Slot shift register and stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid   <= '0;
      slot_load    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_waddr[k] <= '0;
      end
      stall_cycles <= '0;
    end else begin
      if (pipe_en) begin
        slot_valid    <= {slot_valid[DEPTH-2:0], slot0_valid_nxt};
        slot_load     <= {slot_load[DEPTH-2:0], id_MemRead};
        slot_waddr[0] <= id_write_addr;
        for (int k = 1; k < DEPTH; k++) begin
          slot_waddr[k] <= slot_waddr[k-1];
        end
      end
      // Only cycles in which the pipe actually advanced with a bubble count.
      if (stall && pipe_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_forward_scoreboard_id.sv
// ============================================================================
// Module   : tb_forward_scoreboard_id
// Purpose  : Directed self-checking bench for forward_scoreboard_id. A
//            default-parameter instance and a CW=2 instance share stimulus;
//            the second one exercises counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_forward_scoreboard_id;

  localparam int NREAD = 2;
  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int CW    = 16;
  localparam int SW    = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                pipe_en;
  logic                id_valid;
  logic                id_RegWrite;
  logic                id_MemRead;
  logic [AW-1:0]       id_write_addr;
  logic                id_flush;
  logic [NREAD-1:0]    rd_en;
  logic [NREAD*AW-1:0] rd_addr;
  logic [NREAD*SW-1:0] fwd_sel;
  logic                stall;
  logic [CW-1:0]       stall_cycles;
  logic [NREAD*SW-1:0] fwd_sel_s;
  logic                stall_s;
  logic [1:0]          stall_cycles_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  forward_scoreboard_id #(.NREAD(NREAD), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_write_addr(id_write_addr), .id_flush(id_flush), .rd_en(rd_en),
    .rd_addr(rd_addr), .fwd_sel(fwd_sel), .stall(stall),
    .stall_cycles(stall_cycles)
  );

  forward_scoreboard_id #(.NREAD(NREAD), .DEPTH(DEPTH), .AW(AW), .CW(2)) dut_sat (
    .clk(clk), .reset(reset), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_write_addr(id_write_addr), .id_flush(id_flush), .rd_en(rd_en),
    .rd_addr(rd_addr), .fwd_sel(fwd_sel_s), .stall(stall_s),
    .stall_cycles(stall_cycles_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked
  // 1 unit later, well clear of the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid      = 1'b0;
    id_RegWrite   = 1'b0;
    id_MemRead    = 1'b0;
    id_write_addr = '0;
    id_flush      = 1'b0;
    rd_en         = '0;
    rd_addr       = '0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic ld);
    idle();
    id_valid      = 1'b1;
    id_RegWrite   = 1'b1;
    id_MemRead    = ld;
    id_write_addr = a;
  endtask

  task automatic reader(input logic [AW-1:0] a0, input logic en0,
                        input logic [AW-1:0] a1, input logic en1);
    idle();
    id_valid = 1'b1;
    rd_en    = {en1, en0};
    rd_addr  = {a1, a0};
  endtask

  task automatic do_reset();
    idle();
    pipe_en = 1'b1;
    reset   = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] f0();
    return 32'(fwd_sel[SW-1:0]);
  endfunction

  function automatic logic [31:0] f1();
    return 32'(fwd_sel[2*SW-1:SW]);
  endfunction

  initial begin
    idle();
    pipe_en = 1'b1;
    reset   = 1'b1;
    #1;
    do_reset();

    // ---------------- reset state
    settle();
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd", 32'(fwd_sel), 0);
    check("rst_cnt", 32'(stall_cycles), 0);

    // ---------------- ALU chain
    issue(5'd3, 1'b0);
    settle();
    check("alu_issue_stall", 32'(stall), 0);
    step();
    reader(5'd3, 1'b1, 5'd0, 1'b0);
    settle();
    check("alu_use_stall", 32'(stall), 1);
    check("alu_use_fwd", f0(), 0);
    step();
    settle();
    check("alu_fwd1", f0(), 1);
    check("alu_nostall", 32'(stall), 0);
    check("alu_cnt", 32'(stall_cycles), 1);

    // ---------------- load-use
    do_reset();
    issue(5'd4, 1'b1);
    step();
    reader(5'd0, 1'b0, 5'd4, 1'b1);
    settle();
    check("lu_stall_a", 32'(stall), 1);
    check("lu_fwd_a", f1(), 0);
    step();
    settle();
    check("lu_stall_b", 32'(stall), 1);
    step();
    settle();
    check("lu_nostall", 32'(stall), 0);
    check("lu_fwd2", f1(), 2);
    check("lu_cnt", 32'(stall_cycles), 2);

    // ---------------- priority: $5 in slots 1 and 2
    do_reset();
    issue(5'd5, 1'b0);
    step();
    issue(5'd5, 1'b0);
    step();
    idle();
    step();
    reader(5'd5, 1'b1, 5'd5, 1'b1);
    settle();
    check("prio_fwd_p0", f0(), 1);
    check("prio_fwd_p1", f1(), 1);
    check("prio_stall", 32'(stall), 0);

    // younger not-ready match in slot 0 beats older ready one in slot 2
    do_reset();
    issue(5'd5, 1'b0);
    step();
    idle();
    step();
    issue(5'd5, 1'b0);
    step();
    reader(5'd5, 1'b1, 5'd0, 1'b0);
    settle();
    check("young_stall", 32'(stall), 1);
    check("young_fwd", f0(), 0);

    // $0 is never tracked
    do_reset();
    issue(5'd0, 1'b0);
    step();
    reader(5'd0, 1'b1, 5'd0, 1'b1);
    settle();
    check("zero_fwd", 32'(fwd_sel), 0);
    check("zero_stall", 32'(stall), 0);

    // ---------------- freeze during load-use
    do_reset();
    issue(5'd4, 1'b1);
    step();
    reader(5'd4, 1'b1, 5'd0, 1'b0);
    settle();
    check("frz_pre_stall", 32'(stall), 1);
    step();
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("frz_stall", 32'(stall), 1);
      check("frz_cnt", 32'(stall_cycles), 1);
      step();
    end
    settle();
    check("frz_hold_stall", 32'(stall), 1);
    pipe_en = 1'b1;
    step();
    settle();
    check("frz_rel_fwd", f0(), 2);
    check("frz_rel_stall", 32'(stall), 0);
    check("frz_rel_cnt", 32'(stall_cycles), 2);

    // ---------------- flush kills a producer
    do_reset();
    issue(5'd6, 1'b0);
    id_flush = 1'b1;
    step();
    reader(5'd6, 1'b1, 5'd0, 1'b0);
    settle();
    check("flush_stall", 32'(stall), 0);
    step();
    settle();
    check("flush_fwd", f0(), 0);

    // ---------------- reset mid-stall
    do_reset();
    issue(5'd7, 1'b0);
    step();
    reader(5'd7, 1'b1, 5'd0, 1'b0);
    settle();
    check("mid_pre_stall", 32'(stall), 1);
    reset = 1'b1;
    settle();
    check("mid_rst_stall", 32'(stall), 0);
    check("mid_rst_fwd", 32'(fwd_sel), 0);
    step();
    reset = 1'b0;
    settle();
    check("mid_after_fwd", f0(), 0);
    check("mid_after_stall", 32'(stall), 0);
    check("mid_after_cnt", 32'(stall_cycles), 0);

    // ---------------- saturation: 2 + 2 + 1 = 5 stall cycles
    do_reset();
    for (int r = 0; r < 2; r++) begin
      issue(5'd8, 1'b1);
      step();
      reader(5'd8, 1'b1, 5'd0, 1'b0);
      step();
      step();
      step();
    end
    issue(5'd9, 1'b0);
    step();
    reader(5'd9, 1'b1, 5'd0, 1'b0);
    step();
    idle();
    settle();
    check("sat_main_cnt", 32'(stall_cycles), 5);
    check("sat_cw2_cnt", 32'(stall_cycles_s), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
